// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the SRAM arbiter.
//   - FSM state encoding (IDLE / BUSY / COOL)
//   - owner encoding (fetch / data)
//   - default address and data widths
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        COOL = 2'b10
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int unsigned ADDR_W_DEF = 21;
    localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational grant selector for the SRAM arbiter.
// Build option: RAM_ARB_RR_EN selects round-robin between the two ports;
// without it, data always wins over fetch.
// Ports:
//   i_req, d_req  - pending requests
//   last_owner    - current/last grant (0 = fetch, 1 = data)
//   grant_valid   - some request is pending
//   grant_owner   - port to grant when grant_valid
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = i_req | d_req;

`ifdef RAM_ARB_RR_EN
    always_comb begin
        grant_owner = OWNER_I;
        if (i_req && d_req) begin
            // Contended: hand the grant to the port that did not have it last.
            grant_owner = ~last_owner;
        end else if (d_req) begin
            grant_owner = OWNER_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign grant_owner = d_req ? OWNER_D : OWNER_I;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SRAM driver between the instruction-fetch port
// (read only) and the data port (read/write). One transaction at a time;
// address, write data and direction are registered at grant.
// Build option: RAM_ARB_RR_EN (round-robin arbitration, see ram_arb_pick).
// Ports:
//   clk, rst                  - clock, async active-low reset
//   i_req/i_addr/i_rdata/i_ack - fetch port
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack - data port
//   mem_*                     - SRAM driver interface
//   busy                      - high in BUSY and COOL
//   owner                     - current or last grant (0 = fetch, 1 = data)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_enable,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ack,
    output logic              busy,
    output logic              owner
);

    state_t state;
    logic   we_q;
    logic   grant_valid;
    logic   grant_owner;

    ram_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWNER_I;
            we_q        <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_owner;
                        state <= BUSY;
                        if (grant_owner == OWNER_D) begin
                            mem_addr    <= d_addr;
                            mem_data_in <= d_wdata;
                            we_q        <= d_we;
                        end else begin
                            mem_addr <= i_addr;
                            we_q     <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            if (owner == OWNER_D) d_rdata <= mem_data_out;
                            else                  i_rdata <= mem_data_out;
                        end
                        if (owner == OWNER_D) d_ack <= 1'b1;
                        else                  i_ack <= 1'b1;
                        state <= COOL;
                    end
                end
                COOL: begin
                    // One-cycle gap covers the driver's ack tail.
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Masking with mem_ack keeps the driver from restarting on the cycle it
    // returns to idle; mem_addr is left at its last value for its bank mux.
    assign mem_enable       = (state == BUSY) & ~mem_ack;
    assign mem_read_enable  = mem_enable & ~we_q;
    assign mem_write_enable = mem_enable & we_q;
    assign busy             = (state == BUSY) || (state == COOL);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_enable, mem_read_enable, mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_ack;
    logic          busy, owner;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req            (i_req),
        .i_addr           (i_addr),
        .i_rdata          (i_rdata),
        .i_ack            (i_ack),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_rdata          (d_rdata),
        .d_ack            (d_ack),
        .mem_enable       (mem_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_ack          (mem_ack),
        .busy             (busy),
        .owner            (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          own;
        logic          chk_rd;
        logic [DW-1:0] rdata;
    } ack_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } xact_t;

    ack_t  ack_q[$];
    xact_t xq[$];

    int n_cmp = 0;
    int n_fail = 0;
    int starts = 0;
    int n_xact_exp = 0;
    int n_ack_exp = 0;
    int n_ack_seen = 0;
    logic saw_we = 1'b0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {11'h0, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic push_x(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        xact_t x;
        x.addr = a; x.we = we; x.wdata = wd;
        xq.push_back(x);
        n_xact_exp++;
    endtask

    task automatic push_a(input logic own, input logic chk_rd, input logic [DW-1:0] rd);
        ack_t e;
        e.own = own; e.chk_rd = chk_rd; e.rdata = rd;
        ack_q.push_back(e);
        n_ack_exp++;
    endtask

    // Wait (bounded) for an ack on the selected port; sel: 0 fetch, 1 data, 2 either.
    task automatic wait_ack(input int sel, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            cyc++;
            if ((sel == 0 && i_ack) || (sel == 1 && d_ack) || (sel == 2 && (i_ack || d_ack)))
                got = 1'b1;
        end
        chk("ack_wait", {31'h0, got}, 32'h1);
    endtask

    // SRAM driver model: 3 busy cycles then a one-cycle mem_ack.
    logic          active;
    logic [1:0]    cnt;
    logic [AW-1:0] cap_addr;
    logic          cap_we;
    logic [DW-1:0] cap_wdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            active       <= 1'b0;
            cnt          <= '0;
            mem_ack      <= 1'b0;
            mem_data_out <= '0;
        end else begin
            mem_ack <= 1'b0;
            if (active) begin
                if (cnt == 2'd2) begin
                    active  <= 1'b0;
                    mem_ack <= 1'b1;
                    if (cap_we) mem[cap_addr] = cap_wdata;
                    else        mem_data_out <= rd_model(cap_addr);
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end else if (mem_enable) begin
                xact_t x;
                active    <= 1'b1;
                cnt       <= '0;
                cap_addr  <= mem_addr;
                cap_we    <= mem_write_enable;
                cap_wdata <= mem_data_in;
                starts++;
                if (xq.size() > 0) begin
                    x = xq.pop_front();
                    chk("xact_addr", {11'h0, mem_addr}, {11'h0, x.addr});
                    chk("xact_we", {31'h0, mem_write_enable}, {31'h0, x.we});
                    chk("xact_re", {31'h0, mem_read_enable}, {31'h0, ~x.we});
                    if (x.we) chk("xact_wdata", mem_data_in, x.wdata);
                end
            end
        end
    end

    // Ack monitor / scoreboard pop.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_write_enable) saw_we = 1'b1;
            if (mem_ack) chk("enable_gate", {31'h0, mem_enable}, 32'h0);
            if (i_ack || d_ack) begin
                ack_t e;
                n_ack_seen++;
                chk("ack_excl", {31'h0, i_ack & d_ack}, 32'h0);
                if (ack_q.size() > 0) begin
                    e = ack_q.pop_front();
                    chk("ack_port", {31'h0, d_ack}, {31'h0, e.own});
                    chk("owner", {31'h0, owner}, {31'h0, e.own});
                    chk("busy_cool", {31'h0, busy}, 32'h1);
                    if (e.chk_rd) chk("rdata", e.own ? d_rdata : i_rdata, e.rdata);
                end
            end
        end
    end

    task automatic data_xact(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                             input logic [DW-1:0] exp_rd);
        int cyc;
        push_x(a, we, wd);
        push_a(OWNER_D, ~we, exp_rd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        wait_ack(1, cyc);
        d_req = 1'b0;
    endtask

    task automatic fetch_xact(input logic [AW-1:0] a, input logic [DW-1:0] exp_rd,
                              output int cyc);
        push_x(a, 1'b0, '0);
        push_a(OWNER_I, 1'b1, exp_rd);
        i_req = 1'b1; i_addr = a;
        wait_ack(0, cyc);
        i_req = 1'b0;
    endtask

    logic ord [4];

    initial begin
        int cyc;
        mem[21'h000010] = 32'h3C01_BFC0;

        // Reset state
        #12;
        chk("rst_strobes", {27'h0, mem_enable, mem_read_enable, mem_write_enable, busy, owner},
            32'h0);
        chk("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        chk("rst_addr", {11'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_data_in, 32'h0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1. Fetch read with latency check
        saw_we = 1'b0;
        fetch_xact(21'h000010, 32'h3C01_BFC0, cyc);
        chk("fetch_latency", cyc, 32'd6);
        chk("fetch_no_we", {31'h0, saw_we}, 32'h0);
        @(negedge clk);

        // 2. Data write to extra SRAM; address held afterwards
        data_xact(21'h100004, 1'b1, 32'hDEAD_BEEF, '0);
        repeat (3) @(negedge clk);
        chk("addr_hold", {11'h0, mem_addr}, 32'h0010_0004);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // 5. Drop request and change address mid-BUSY
        push_x(21'h000020, 1'b0, '0);
        push_a(OWNER_D, 1'b1, rd_model(21'h000020));
        d_req = 1'b1; d_we = 1'b0; d_addr = 21'h000020;
        repeat (2) @(negedge clk);
        d_req = 1'b0; d_addr = 21'h000999;
        wait_ack(1, cyc);
        repeat (8) @(negedge clk);

        // Read back the write, then a fetch so the last owner is fetch
        data_xact(21'h100004, 1'b0, '0, 32'hDEAD_BEEF);
        @(negedge clk);
        fetch_xact(21'h000010, 32'h3C01_BFC0, cyc);
        @(negedge clk);

        // 3. Contended rounds
`ifdef RAM_ARB_RR_EN
        ord[0] = OWNER_D; ord[1] = OWNER_I; ord[2] = OWNER_D; ord[3] = OWNER_I;
`else
        ord[0] = OWNER_D; ord[1] = OWNER_D; ord[2] = OWNER_D; ord[3] = OWNER_I;
`endif
        for (int k = 0; k < 4; k++) begin
            if (ord[k] == OWNER_D) begin
                push_x(21'h000040, 1'b0, '0);
                push_a(OWNER_D, 1'b1, rd_model(21'h000040));
            end else begin
                push_x(21'h000080, 1'b0, '0);
                push_a(OWNER_I, 1'b1, rd_model(21'h000080));
            end
        end
        i_req = 1'b1; i_addr = 21'h000080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 21'h000040;
        for (int k = 0; k < 4; k++) begin
            wait_ack(2, cyc);
            if (k == 2) d_req = 1'b0;
        end
        i_req = 1'b0;
        repeat (3) @(negedge clk);

        // 6. Asynchronous reset mid-BUSY, then serve a pending fetch
        push_x(21'h000030, 1'b0, '0);
        i_req = 1'b1; i_addr = 21'h000030;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_enable", {31'h0, mem_enable}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        #1 rst = 1'b1;
        push_x(21'h000030, 1'b0, '0);
        push_a(OWNER_I, 1'b1, rd_model(21'h000030));
        wait_ack(0, cyc);
        i_req = 1'b0;
        repeat (4) @(negedge clk);

        // 4. One driver start per grant; scoreboards drained
        chk("driver_starts", starts, n_xact_exp);
        chk("xact_left", xq.size(), 32'h0);
        chk("ack_count", n_ack_seen, n_ack_exp);
        chk("ack_left", ack_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
